// File: rtl/xor_seq_pkg.sv
// Shared types and default widths for the XOR vector sequencer.
package xor_seq_pkg;
  localparam int IN_W_D  = 20;
  localparam int OUT_W_D = 10;
  localparam int CNT_W_D = 16;
  localparam logic [OUT_W_D-1:0] OUT_MASK_D = 10'h00F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_PRESENT,
    S_FIN
  } state_e;
endpackage

// File: rtl/seq_down_counter.sv
// 4-bit settle counter: load, decrement-to-zero, zero flag.
module seq_down_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == 4'd0);
endmodule

// File: rtl/xor_vector_sequencer.sv
// Drives vectors into the XOR datapath, waits a settle time, and streams
// back masked, indexed results with valid/ready on both sides.
module xor_vector_sequencer
  import xor_seq_pkg::*;
#(
  parameter int               IN_W          = IN_W_D,
  parameter int               OUT_W         = OUT_W_D,
  parameter int               SETTLE_CYCLES = 1,
  parameter int               CNT_W         = CNT_W_D,
  parameter logic [OUT_W-1:0] OUT_MASK      = OUT_W'(OUT_MASK_D)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             vec_valid,
  input  logic [IN_W-1:0]  vec_data,
  output logic             vec_ready,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             res_valid,
  output logic [OUT_W-1:0] res_data,
  output logic [CNT_W-1:0] res_index,
  input  logic             res_ready,
  output logic             busy,
  output logic             done
);
  state_e           state, state_nxt;
  logic [CNT_W-1:0] idx, nvec, idx_inc;
  logic             start_go, vec_fire, cap, res_fire, settle_dec, cnt_zero;

  assign idx_inc = idx + CNT_W'(1);

  // abort overrides every state, so all strobes below are implicitly gated by it
  always_comb begin
    state_nxt  = state;
    start_go   = 1'b0;
    vec_fire   = 1'b0;
    cap        = 1'b0;
    res_fire   = 1'b0;
    settle_dec = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          start_go  = 1'b1;
          state_nxt = (num_vec == '0) ? S_FIN : S_LOAD;
        end
        S_LOAD: if (vec_valid) begin
          vec_fire  = 1'b1;
          state_nxt = S_SETTLE;
        end
        S_SETTLE: if (cnt_zero) begin
          cap       = 1'b1;
          state_nxt = S_PRESENT;
        end else begin
          settle_dec = 1'b1;
        end
        S_PRESENT: if (res_ready) begin
          res_fire  = 1'b1;
          state_nxt = (idx_inc == nvec) ? S_FIN : S_LOAD;
        end
        S_FIN:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign vec_ready = (state == S_LOAD) && !abort;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FIN) && !abort;

  seq_down_counter u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (vec_fire),
    .dec      (settle_dec),
    .load_val (4'(SETTLE_CYCLES - 1)),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dut_in    <= '0;
      res_data  <= '0;
      res_index <= '0;
      res_valid <= 1'b0;
      idx       <= '0;
      nvec      <= '0;
    end else begin
      state <= state_nxt;
      if (start_go) begin
        nvec <= num_vec;
        idx  <= '0;
      end
      if (vec_fire) dut_in <= vec_data;
      if (cap) begin
        res_data  <= dut_out & OUT_MASK;
        res_index <= idx;
      end
      if (abort)         res_valid <= 1'b0;
      else if (cap)      res_valid <= 1'b1;
      else if (res_fire) res_valid <= 1'b0;
      if (res_fire) idx <= idx_inc;
    end
  end
endmodule
